mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter WAIT_STATES, default 1: fixed strobe cycles before mem_ready is sampled (0..15).
REQ-002 Parameter TIMEOUT, default 255: maximum cycles spent waiting for mem_ready (1..255).
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 cpu_req  in  1  transaction request from CPU6, sampled only in IDLE.
REQ-006 cpu_we  in  1  1 = write, 0 = read; latched with cpu_req.
REQ-007 cpu_addr  in  16  logical address; latched with cpu_req.
REQ-008 cpu_wdata  in  8  write data; latched with cpu_req.
REQ-009 cpu_busy  out  1  high in every state except IDLE.
REQ-010 cpu_done  out  1  one-cycle completion pulse.
REQ-011 cpu_rdata  out  8  read data; valid while cpu_done is high, then held until the next completion.
REQ-012 cpu_fault  out  1  high with cpu_done when the transaction timed out.
REQ-013 pt_we  in  1  page-table write strobe.
REQ-014 pt_index  in  5  page-table entry select.
REQ-015 pt_data  in  7  physical page number to write.
REQ-016 mem_addr  out  18  physical address.
REQ-017 mem_dout  out  8  write data to the top-level tristate.
REQ-018 mem_oe  out  1  data drive enable for the top-level tristate.
REQ-019 mem_rd, mem_wr  out  1 each  read and write strobes.
REQ-020 mem_din  in  8  read data from memory.
REQ-021 mem_ready  in  1  memory ready; low inserts wait cycles.

Function
REQ-022 The page table has 32 entries of 7 bits; translation is mem_addr = {pt[cpu_addr[15:11]], cpu_addr[10:0]}.
REQ-023 A page-table write updates the entry at the clock edge; a lookup in the same cycle returns the old value.
REQ-024 The FSM states are IDLE, XLATE, STROBE, WAITRDY and DONE.
REQ-025 IDLE: when cpu_req=1, latch we, addr and wdata and go to XLATE; otherwise stay in IDLE.
REQ-026 XLATE: register mem_addr from the translated address and go to STROBE.
REQ-027 STROBE: assert mem_rd (read) or mem_wr plus mem_oe (write) for WAIT_STATES cycles, then go to WAITRDY; with WAIT_STATES=0, go straight to WAITRDY.
REQ-028 WAITRDY: keep the strobes asserted.
  - mem_ready=1: capture mem_din into cpu_rdata on reads and go to DONE.
  - Otherwise increment the timeout counter.
  - Counter reaching TIMEOUT: set fault, set cpu_rdata=8'hFF on reads, go to DONE.
REQ-029 DONE: pulse cpu_done for one cycle with cpu_fault valid; all strobes low; go to IDLE.
REQ-030 Latency: with WAIT_STATES=0 and mem_ready=1, cpu_req sampled at edge N gives cpu_done high in cycle N+3.
REQ-031 cpu_req in any state other than IDLE is ignored; back-to-back transactions have a minimum spacing of one IDLE cycle.
REQ-032 mem_addr and mem_dout stay stable from XLATE through DONE.
REQ-033 mem_rd and mem_wr are never high in the same cycle.
REQ-034 Write transactions leave cpu_rdata unchanged.

Reset
REQ-035 Reset puts the FSM in IDLE.
REQ-036 Reset clears every output to 0: cpu_busy, cpu_done, cpu_fault, cpu_rdata, mem_rd, mem_wr, mem_oe, mem_addr, mem_dout.
REQ-037 Reset loads page-table entry i with the value i (identity map, upper 2 bits zero).
REQ-038 Reset mid-transaction aborts it: no cpu_done pulse, strobes low on the next cycle.

Structure
REQ-039 The FSM state encoding, the page-table width (7) and the address widths (16/18) are defined in a shared package.
REQ-040 The page table is a sub-module, page_table, with one write port and one asynchronous read port.

Verification
REQ-041 Reset, then read 16'h0805 with mem_ready=1 and mem_din=8'h3C -> mem_addr=18'h00805; cpu_done with cpu_rdata=8'h3C, cpu_fault=0.
REQ-042 Write pt[1]=7'h45, then read 16'h0805 -> mem_addr=18'h22805.
REQ-043 WAIT_STATES=0; write 16'h1234 with data 8'hA5 and mem_ready=1 -> mem_wr and mem_oe high for 1 cycle, mem_dout=8'hA5, cpu_done in cycle N+3.
REQ-044 Hold mem_ready=0 with TIMEOUT=4 -> cpu_done plus cpu_fault=1, cpu_rdata=8'hFF; then read 8'h11 normally -> cpu_fault=0.
REQ-045 Drive reset low during WAITRDY -> cpu_done never pulses; next cycle state is IDLE, strobes low, page table back to identity.
REQ-046 Assert pt_we for index 0 in the same cycle as XLATE -> the current transaction uses the old entry, the next transaction uses the new one.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg: shared widths, FSM state encoding and address translation helper.
package mem_bus_ctrl_pkg;
    localparam int VA_W     = 16;
    localparam int PT_IDX_W = 5;
    localparam int PT_N     = 1 << PT_IDX_W;
    localparam int OFF_W    = VA_W - PT_IDX_W;
    localparam int PT_W     = 7;
    localparam int PA_W     = PT_W + OFF_W;
    localparam int DATA_W   = 8;
    typedef enum logic [2:0] {IDLE, XLATE, STROBE, WAITRDY, DONE} state_t;
    function automatic logic [PA_W-1:0] xlate(input logic [PT_W-1:0] page, input logic [OFF_W-1:0] off);
        return {page, off};
    endfunction
endpackage

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: CPU, page-table and memory bus signals of the controller.
//   master: CPU/memory side (drives requests, page-table writes, memory read data/ready)
//   slave : controller side (drives completion, read data, physical address and strobes)
interface mem_bus_ctrl_if;
    import mem_bus_ctrl_pkg::*;
    logic              cpu_req;
    logic              cpu_we;
    logic [VA_W-1:0]   cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_busy;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_fault;
    logic              pt_we;
    logic [PT_IDX_W-1:0] pt_index;
    logic [PT_W-1:0]   pt_data;
    logic [PA_W-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_oe;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_ready;
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, pt_we, pt_index, pt_data, mem_din, mem_ready,
        input  cpu_busy, cpu_done, cpu_rdata, cpu_fault, mem_addr, mem_dout, mem_oe, mem_rd, mem_wr
    );
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, pt_we, pt_index, pt_data, mem_din, mem_ready,
        output cpu_busy, cpu_done, cpu_rdata, cpu_fault, mem_addr, mem_dout, mem_oe, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_bus_ctrl_page_table.sv
// page_table: 32 x 7-bit page table, one synchronous write port, one asynchronous read port.
//   clock, reset (sync, active-low: loads identity map), we/wr_index/wr_data write port,
//   rd_index/rd_data read port (returns the pre-write value in the cycle of a write).
module page_table
    import mem_bus_ctrl_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                we,
    input  logic [PT_IDX_W-1:0] wr_index,
    input  logic [PT_W-1:0]     wr_data,
    input  logic [PT_IDX_W-1:0] rd_index,
    output logic [PT_W-1:0]     rd_data
);
    logic [PT_W-1:0] pt [PT_N];
    always_ff @(posedge clock)
        if (!reset)
            for (int i = 0; i < PT_N; i++) pt[i] <= PT_W'(i);
        else if (we)
            pt[wr_index] <= wr_data;
    assign rd_data = pt[rd_index];
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU-to-memory bus controller with page-table address translation,
// fixed strobe wait states, ready wait with timeout and a one-cycle completion pulse.
//   clock, reset (sync, active-low), bus (mem_bus_ctrl_if.slave: CPU request/completion,
//   page-table write port, physical memory address/data/strobes/ready).
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 255
)
(
    input  logic         clock,
    input  logic         reset,
    mem_bus_ctrl_if.slave bus
);
    state_t            state, state_n;
    logic [7:0]        cnt;
    logic              we_q;
    logic [VA_W-1:0]   addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              fault_q;
    logic [PA_W-1:0]   pa_q;
    logic [PT_W-1:0]   page;
    logic              strobe;
    logic              last_strobe;
    logic              timed_out;

    page_table u_pt (
        .clock    (clock),
        .reset    (reset),
        .we       (bus.pt_we),
        .wr_index (bus.pt_index),
        .wr_data  (bus.pt_data),
        .rd_index (addr_q[VA_W-1:OFF_W]),
        .rd_data  (page)
    );

    // cnt restarts on every state change, so it counts cycles spent in the current state
    assign last_strobe = cnt == 8'(WAIT_STATES - 1);
    assign timed_out   = cnt == 8'(TIMEOUT - 1);

    always_ff @(posedge clock)
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;

    always_comb begin
        state_n = state;
        strobe  = 1'b0;
        case (state)
            IDLE:    state_n = bus.cpu_req ? XLATE : IDLE;
            XLATE:   state_n = WAIT_STATES == 0 ? WAITRDY : STROBE;
            STROBE: begin
                strobe  = 1'b1;
                state_n = last_strobe ? WAITRDY : STROBE;
            end
            WAITRDY: begin
                strobe  = 1'b1;
                state_n = (bus.mem_ready || timed_out) ? DONE : WAITRDY;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock)
        if (!reset) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            pa_q    <= '0;
        end else begin
            cnt <= state_n == state ? cnt + 8'd1 : 8'd0;
            if (state == IDLE && bus.cpu_req) begin
                we_q    <= bus.cpu_we;
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
                fault_q <= 1'b0;
            end
            if (state == XLATE)
                pa_q <= xlate(page, addr_q[OFF_W-1:0]);
            // a ready seen on the final allowed cycle still completes normally
            if (state == WAITRDY) begin
                if (bus.mem_ready) begin
                    if (!we_q) rdata_q <= bus.mem_din;
                end else if (timed_out) begin
                    fault_q <= 1'b1;
                    if (!we_q) rdata_q <= '1;
                end
            end
        end

    assign bus.cpu_busy  = state != IDLE;
    assign bus.cpu_done  = state == DONE;
    assign bus.cpu_fault = state == DONE && fault_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.mem_addr  = pa_q;
    assign bus.mem_dout  = wdata_q;
    assign bus.mem_rd    = strobe && !we_q;
    assign bus.mem_wr    = strobe && we_q;
    assign bus.mem_oe    = strobe && we_q;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: table-driven, directed and randomised checks of two mem_bus_ctrl configurations
// against a transaction-window model.
module tb_mem_bus_ctrl;
    import mem_bus_ctrl_pkg::*;
    localparam int WS_A = 0;
    localparam int TO_A = 4;
    localparam int WS_B = 2;
    localparam int TO_B = 6;

    typedef struct packed {
        logic        busy, done, fault, rd, wr, oe;
        logic [7:0]  rdata, dout;
        logic [17:0] maddr;
    } obs_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata, din;
        logic [31:0] mask;
        bit          pw;
        logic [4:0]  pidx;
        logic [6:0]  pdat;
        logic [17:0] epa;
        logic [7:0]  erd;
        logic        ef;
        int          edn;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_bus_ctrl_if ia();
    mem_bus_ctrl_if ib();
    assign ib.cpu_req   = ia.cpu_req;
    assign ib.cpu_we    = ia.cpu_we;
    assign ib.cpu_addr  = ia.cpu_addr;
    assign ib.cpu_wdata = ia.cpu_wdata;
    assign ib.pt_we     = ia.pt_we;
    assign ib.pt_index  = ia.pt_index;
    assign ib.pt_data   = ia.pt_data;
    assign ib.mem_din   = ia.mem_din;
    assign ib.mem_ready = ia.mem_ready;

    mem_bus_ctrl #(.WAIT_STATES(WS_A), .TIMEOUT(TO_A)) dut_a (.clock(clock), .reset(reset), .bus(ia.slave));
    mem_bus_ctrl #(.WAIT_STATES(WS_B), .TIMEOUT(TO_B)) dut_b (.clock(clock), .reset(reset), .bus(ib.slave));

    obs_t o [2];
    assign o[0] = {ia.cpu_busy, ia.cpu_done, ia.cpu_fault, ia.mem_rd, ia.mem_wr, ia.mem_oe, ia.cpu_rdata, ia.mem_dout, ia.mem_addr};
    assign o[1] = {ib.cpu_busy, ib.cpu_done, ib.cpu_fault, ib.mem_rd, ib.mem_wr, ib.mem_oe, ib.cpu_rdata, ib.mem_dout, ib.mem_addr};

    int checks = 0;
    int failures = 0;
    int ws [2];
    int tmo [2];
    logic [6:0]  mpt [32];
    logic [7:0]  mrd [2];
    int          obs_dn [2];
    logic [17:0] obs_pa [2];
    logic [7:0]  obs_rd [2];
    logic        obs_flt [2];
    vec_t        tbl [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 2; k++) chk($sformatf("reset_outputs d%0d", k), o[k], '0);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) mpt[i] = 7'(i);
        mrd[0] = 8'h00;
        mrd[1] = 8'h00;
    endtask

    task automatic pt_write(input logic [4:0] idx, input logic [6:0] data);
        @(negedge clock);
        ia.pt_we = 1'b1;
        ia.pt_index = idx;
        ia.pt_data = data;
        mpt[idx] = data;
        @(negedge clock);
        ia.pt_we = 1'b0;
    endtask

    // Expected behaviour per DUT: cycle 0 is the translate cycle after acceptance, strobes run
    // from cycle 1 until the completion cycle, the ready window opens after the wait states and
    // lasts at most the timeout, and completion follows the first ready inside that window.
    task automatic txn(input logic we, input logic [15:0] addr, input logic [7:0] wdata, input logic [7:0] din,
                       input logic [31:0] mask, input bit rnd, input bit pw0, input logic [6:0] pw0_data);
        logic [7:0]  dins [32];
        logic [17:0] pa;
        int          dn [2];
        logic        flt [2];
        logic [7:0]  erd [2];
        int          first, last;
        bit          stb;
        pa = {mpt[addr[15:11]], addr[10:0]};
        for (int c = 0; c < 32; c++) dins[c] = rnd ? 8'($urandom) : din;
        for (int k = 0; k < 2; k++) begin
            dn[k] = 1 + ws[k] + tmo[k];
            flt[k] = 1'b1;
            erd[k] = we ? mrd[k] : 8'hFF;
            for (int c = ws[k] + tmo[k]; c >= 1 + ws[k]; c--)
                if (mask[c]) begin
                    dn[k] = c + 1;
                    flt[k] = 1'b0;
                    erd[k] = we ? mrd[k] : dins[c];
                end
            obs_dn[k] = -1;
        end
        first = dn[0] < dn[1] ? dn[0] : dn[1];
        last  = dn[0] > dn[1] ? dn[0] : dn[1];
        @(negedge clock);
        for (int k = 0; k < 2; k++) chk($sformatf("idle_busy d%0d", k), o[k].busy, 0);
        ia.cpu_req = 1'b1;
        ia.cpu_we = we;
        ia.cpu_addr = addr;
        ia.cpu_wdata = wdata;
        ia.pt_we = 1'b0;
        for (int c = 0; c <= last + 1; c++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                stb = c >= 1 && c < dn[k];
                chk($sformatf("busy d%0d c%0d", k, c), o[k].busy, c <= dn[k]);
                chk($sformatf("done d%0d c%0d", k, c), o[k].done, c == dn[k]);
                chk($sformatf("fault d%0d c%0d", k, c), o[k].fault, c == dn[k] && flt[k]);
                chk($sformatf("mem_rd d%0d c%0d", k, c), o[k].rd, stb && !we);
                chk($sformatf("mem_wr d%0d c%0d", k, c), o[k].wr, stb && we);
                chk($sformatf("mem_oe d%0d c%0d", k, c), o[k].oe, stb && we);
                chk($sformatf("rdata d%0d c%0d", k, c), o[k].rdata, c >= dn[k] ? erd[k] : mrd[k]);
                if (c >= 1 && c <= dn[k]) begin
                    chk($sformatf("mem_addr d%0d c%0d", k, c), o[k].maddr, pa);
                    chk($sformatf("mem_dout d%0d c%0d", k, c), o[k].dout, wdata);
                end
                if (o[k].done) begin
                    obs_dn[k] = c;
                    obs_pa[k] = o[k].maddr;
                    obs_rd[k] = o[k].rdata;
                    obs_flt[k] = o[k].fault;
                end
            end
            ia.cpu_req = rnd && c < first ? 1'($urandom) : 1'b0;
            if (rnd) begin
                ia.cpu_we = 1'($urandom);
                ia.cpu_addr = 16'($urandom);
                ia.cpu_wdata = 8'($urandom);
            end
            ia.mem_ready = mask[c];
            ia.mem_din = dins[c];
            ia.pt_we = 1'b0;
            if (c == 0 && pw0) begin
                ia.pt_we = 1'b1;
                ia.pt_index = 5'd0;
                ia.pt_data = pw0_data;
            end else if (rnd && c <= last && $urandom_range(0, 3) == 0) begin
                ia.pt_we = 1'b1;
                ia.pt_index = 5'($urandom);
                ia.pt_data = 7'($urandom);
            end
            if (ia.pt_we) mpt[ia.pt_index] = ia.pt_data;
        end
        for (int k = 0; k < 2; k++) mrd[k] = erd[k];
    endtask

    initial begin
        ws[0] = WS_A;
        ws[1] = WS_B;
        tmo[0] = TO_A;
        tmo[1] = TO_B;
        ia.cpu_req = 1'b0;
        ia.cpu_we = 1'b0;
        ia.cpu_addr = '0;
        ia.cpu_wdata = '0;
        ia.pt_we = 1'b0;
        ia.pt_index = '0;
        ia.pt_data = '0;
        ia.mem_din = '0;
        ia.mem_ready = 1'b1;
        repeat (2) @(posedge clock);
        apply_reset();

        //           we    addr      wdata  din    mask          pw    pidx  pdat   epa        erd    ef    edn
        tbl[0] = '{1'b0, 16'h0805, 8'h00, 8'h3C, 32'hFFFFFFFF, 1'b0, 5'd0, 7'h00, 18'h00805, 8'h3C, 1'b0, 2};
        tbl[1] = '{1'b0, 16'h0805, 8'h00, 8'h5A, 32'hFFFFFFFF, 1'b1, 5'd1, 7'h45, 18'h22805, 8'h5A, 1'b0, 2};
        tbl[2] = '{1'b1, 16'h1234, 8'hA5, 8'h00, 32'hFFFFFFFF, 1'b0, 5'd0, 7'h00, 18'h01234, 8'h5A, 1'b0, 2};
        tbl[3] = '{1'b0, 16'h0000, 8'h00, 8'h00, 32'h00000000, 1'b0, 5'd0, 7'h00, 18'h00000, 8'hFF, 1'b1, 5};
        tbl[4] = '{1'b0, 16'hF800, 8'h00, 8'h11, 32'hFFFFFFFF, 1'b0, 5'd0, 7'h00, 18'h0F800, 8'h11, 1'b0, 2};
        tbl[5] = '{1'b0, 16'h7FFF, 8'h00, 8'h77, 32'hFFFFFFFC, 1'b0, 5'd0, 7'h00, 18'h07FFF, 8'h77, 1'b0, 3};
        tbl[6] = '{1'b0, 16'h0001, 8'h00, 8'h99, 32'h00000010, 1'b0, 5'd0, 7'h00, 18'h00001, 8'h99, 1'b0, 5};
        tbl[7] = '{1'b1, 16'h0802, 8'h3C, 8'h00, 32'h00000000, 1'b0, 5'd0, 7'h00, 18'h22802, 8'h99, 1'b1, 5};
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].pw) pt_write(tbl[i].pidx, tbl[i].pdat);
            txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].din, tbl[i].mask, 1'b0, 1'b0, 7'h00);
            chk($sformatf("tbl%0d done_cycle", i), obs_dn[0], tbl[i].edn);
            chk($sformatf("tbl%0d mem_addr", i), obs_pa[0], tbl[i].epa);
            chk($sformatf("tbl%0d rdata", i), obs_rd[0], tbl[i].erd);
            chk($sformatf("tbl%0d fault", i), obs_flt[0], tbl[i].ef);
        end

        // page-table write during the translate cycle: old entry now, new entry next time
        txn(1'b0, 16'h0123, 8'h00, 8'h42, 32'hFFFFFFFF, 1'b0, 1'b1, 7'h7F);
        chk("xlate_write old_entry", obs_pa[0], 18'h00123);
        txn(1'b0, 16'h0123, 8'h00, 8'h43, 32'hFFFFFFFF, 1'b0, 1'b0, 7'h00);
        chk("xlate_write new_entry", obs_pa[0], 18'h3F923);

        // reset while waiting for ready aborts the transaction and restores the identity map
        pt_write(5'd3, 7'h2A);
        @(negedge clock);
        ia.cpu_req = 1'b1;
        ia.cpu_we = 1'b0;
        ia.cpu_addr = 16'h1800;
        ia.mem_ready = 1'b0;
        @(negedge clock);
        ia.cpu_req = 1'b0;
        repeat (2) @(negedge clock);
        chk("abort waitrdy mem_rd", o[0].rd, 1);
        apply_reset();
        repeat (6) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("abort no_done d%0d", k), o[k].done, 0);
                chk($sformatf("abort idle d%0d", k), o[k].busy, 0);
            end
        end
        txn(1'b0, 16'h1800, 8'h00, 8'h66, 32'hFFFFFFFF, 1'b0, 1'b0, 7'h00);
        chk("abort identity_restored", obs_pa[0], 18'h01800);

        for (int i = 0; i < 150; i++) begin
            int r;
            logic [31:0] m;
            r = $urandom_range(0, 3);
            m = r == 0 ? 32'h0 : r == 1 ? 32'hFFFFFFFF : $urandom & $urandom;
            txn(1'($urandom), 16'($urandom), 8'($urandom), 8'h00, m, 1'b1, 1'b0, 7'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
